uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop rxd synchronizer, prescaled oversampling bit grid aligned to the
// detected start edge, LSB-first shift register and a one-cycle data-ready strobe.
module uart_rx #(
   parameter int         data_bits                 = 8,
   parameter int         received_bit_counter_bits = 3,
   parameter int         bit_cell_counter_bits     = 4,
   parameter logic [2:0] br                        = 3'b000
) (
   input  logic                 sysclk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [data_bits-1:0] RDR,
   output logic                 rxd_readyH
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   localparam int unsigned DIV = 32'd3 << br;
   localparam int          PW  = $clog2(DIV);
   localparam int          CW  = bit_cell_counter_bits;
   localparam int          BW  = received_bit_counter_bits;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [CW-1:0] CELL_MID   = CW'((1 << (CW - 1)) - 1);
   localparam logic [CW-1:0] CELL_LAST  = '1;
   localparam logic [BW-1:0] BIT_LAST   = BW'(data_bits - 1);

   logic                 sync0_q, sync0_d;
   logic                 sync1_q, sync1_d;
   logic [2:0]           state_q, state_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [CW-1:0]        cell_q, cell_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [data_bits-1:0] shift_q, shift_d;
   logic [data_bits-1:0] rdr_q, rdr_d;
   logic                 ready_q, ready_d;
   logic                 rxd_s;
   logic                 tick;

   assign rxd_s = sync1_q;
   assign tick  = (presc_q == PRESC_LAST);

   always_comb begin
      sync0_d = rxd;
      sync1_d = sync0_q;
      state_d = state_q;
      presc_d = tick ? '0 : presc_q + PW'(1);
      cell_d  = cell_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      rdr_d   = rdr_q;
      ready_d = 1'b0;

      case (state_q)
         IDLE: begin
            // Restarting the prescaler here lines the bit grid up with the falling edge.
            if (!rxd_s) begin
               state_d = START;
               cell_d  = '0;
               presc_d = '0;
            end
         end
         START: begin
            if (tick) begin
               if (cell_q == CELL_MID) begin
                  if (rxd_s) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     cell_d  = '0;
                     bit_d   = '0;
                  end
               end else begin
                  cell_d = cell_q + CW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               cell_d = cell_q + CW'(1);
               if (cell_q == CELL_LAST) begin
                  shift_d = {rxd_s, shift_q[data_bits-1:1]};
                  bit_d   = bit_q + BW'(1);
                  if (bit_q == BIT_LAST) begin
                     state_d = STOP;
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               cell_d = cell_q + CW'(1);
               if (cell_q == CELL_LAST) begin
                  if (rxd_s) begin
                     rdr_d   = shift_q;
                     ready_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = WAIT_HIGH;
                  end
               end
            end
         end
         WAIT_HIGH: begin
            if (rxd_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge rst_n) begin
      if (rst_n) begin
         sync0_q <= 1'b1;
         sync1_q <= 1'b1;
         state_q <= IDLE;
         presc_q <= '0;
         cell_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         rdr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         sync0_q <= sync0_d;
         sync1_q <= sync1_d;
         state_q <= state_d;
         presc_q <= presc_d;
         cell_q  <= cell_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         rdr_q   <= rdr_d;
         ready_q <= ready_d;
      end
   end

   assign RDR        = rdr_q;
   assign rxd_readyH = ready_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (br=000, 48 sysclk per bit).
module tb_uart_rx;

   logic       sysclk;
   logic       rst_n;
   logic       rxd;
   logic [7:0] RDR;
   logic       rxd_readyH;

   int         passed;
   int         total;
   int         cyc;
   int         strobe_cnt;
   int         t_edge;
   int         t_log [16];
   logic [7:0] rdr_log [16];

   uart_rx dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .rxd        (rxd),
      .RDR        (RDR),
      .rxd_readyH (rxd_readyH)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   // Every high sample of the strobe counts, so a stretched pulse inflates the count.
   initial strobe_cnt = 0;
   always @(negedge sysclk) begin
      if (rxd_readyH) begin
         if (strobe_cnt < 16) begin
            t_log[strobe_cnt]   <= cyc;
            rdr_log[strobe_cnt] <= RDR;
         end
         strobe_cnt <= strobe_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (48) @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      t_edge = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b1;
      rxd    = 1'b1;

      // Reset held with the line toggling
      for (int i = 0; i < 20; i++) begin
         @(negedge sysclk);
         rxd = ~rxd;
         if (i % 5 == 4) begin
            check("reset_rdr_ready", {23'd0, rxd_readyH, RDR}, 32'h0);
         end
      end
      rxd = 1'b1;
      @(negedge sysclk);
      rst_n = 1'b0;
      idle(100);

      // Good frame 0xA5
      send_frame(8'hA5, 1'b1);
      idle(100);
      check("a5_strobes", strobe_cnt, 1);
      check("a5_rdr", RDR, 8'hA5);
      check("a5_latency_457_461",
            ((t_log[0] - t_edge) >= 457 && (t_log[0] - t_edge) <= 461), 1);

      // False start glitch, then 0x3C
      rxd = 1'b0;
      repeat (10) @(negedge sysclk);
      idle(200);
      check("glitch_strobes", strobe_cnt, 1);
      check("glitch_rdr", RDR, 8'hA5);
      send_frame(8'h3C, 1'b1);
      idle(100);
      check("3c_strobes", strobe_cnt, 2);
      check("3c_rdr", RDR, 8'h3C);

      // Framing error: stop low, line low 5 bit times total, then high
      send_frame(8'h5A, 1'b0);
      repeat (4) send_bit(1'b0);
      idle(100);
      check("frame_err_strobes", strobe_cnt, 2);
      check("frame_err_rdr", RDR, 8'h3C);
      send_frame(8'hFF, 1'b1);
      idle(100);
      check("ff_strobes", strobe_cnt, 3);
      check("ff_rdr", RDR, 8'hFF);

      // Back-to-back 0x00 then 0xFF
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(100);
      check("b2b_strobes", strobe_cnt, 5);
      check("b2b_rdr_first", rdr_log[3], 8'h00);
      check("b2b_rdr_second", rdr_log[4], 8'hFF);
      check("b2b_interval", t_log[4] - t_log[3], 480);

      // Reset during data bit 3
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      rxd = 1'b0;
      repeat (24) @(negedge sysclk);
      rst_n = 1'b1;
      repeat (3) @(negedge sysclk);
      check("midreset_rdr", RDR, 8'h00);
      check("midreset_ready", rxd_readyH, 1'b0);
      rxd = 1'b1;
      repeat (5) @(negedge sysclk);
      rst_n = 1'b0;
      idle(600);
      check("midreset_no_strobe", strobe_cnt, 5);
      check("midreset_rdr_after", RDR, 8'h00);
      send_frame(8'h81, 1'b1);
      idle(100);
      check("81_strobes", strobe_cnt, 6);
      check("81_rdr", RDR, 8'h81);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
